// File: rtl/dm_bus_sequencer.sv
// MEM-stage data-memory sequencer onto a req/ack bus with wait states and a transfer timeout.
// Optional performance counters are built when DM_BUS_PERF_CNT_EN is defined.
module dm_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  mem_we,
  input  logic [3:0]  mem_re,
  input  logic        load_signed,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_timeout,
  output logic        illegal_req
`ifdef DM_BUS_PERF_CNT_EN
  ,
  output logic [31:0] perf_txn_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lsgn_p1;
  logic             access, start, to_hit;
  logic             addr_lsb_unused;

  function automatic logic [31:0] lane_wdata(input logic [3:0] be, input logic [31:0] d);
    logic [31:0] r;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: r = {4{d[7:0]}};
      4'b0011, 4'b1100:                   r = {2{d[15:0]}};
      default:                            r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] be, input logic [31:0] w,
                                               input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[7:0];
    h = w[15:0];
    case (be)
      4'b0010: b = w[15:8];
      4'b0100: b = w[23:16];
      4'b1000: b = w[31:24];
      4'b1100: h = w[31:16];
      default: ;
    endcase
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: r = {{24{sgn & b[7]}}, b};
      4'b0011, 4'b1100:                   r = {{16{sgn & h[15]}}, h};
      default:                            r = w;
    endcase
    return r;
  endfunction

  assign addr_lsb_unused = ^mem_addr[1:0];
  assign access = (mem_we != 4'b0) || (mem_re != 4'b0);
  assign start  = (state == IDLE) && access;
  assign to_hit = (state == REQ) && !bus_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access) state_nxt = REQ;
      REQ:     if (bus_ack || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req     = (state == REQ);
    stall       = reset_n && (start || (state == REQ));
    rdata_valid = (state == DONE) && !bus_we;
    illegal_req = reset_n && (state == IDLE) && (mem_we != 4'b0) && (mem_re != 4'b0);
  end

  // request capture in IDLE, completion or abandonment in REQ
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_we      <= 1'b0;
      bus_be      <= 4'b0;
      bus_addr    <= 32'b0;
      bus_wdata   <= 32'b0;
      rdata       <= 32'b0;
      bus_timeout <= 1'b0;
      cnt         <= '0;
      lsgn_p1     <= 1'b0;
    end else if (start) begin
      bus_we    <= (mem_we != 4'b0);
      bus_be    <= (mem_we != 4'b0) ? mem_we : mem_re;
      bus_addr  <= {mem_addr[31:2], 2'b00};
      bus_wdata <= lane_wdata(mem_we, mem_wdata);
      lsgn_p1   <= load_signed;
      cnt       <= '0;
    end else if (state == REQ) begin
      if (bus_ack) begin
        if (!bus_we) rdata <= load_extract(bus_be, bus_rdata, lsgn_p1);
      end else if (to_hit) begin
        bus_timeout <= 1'b1;
        rdata       <= 32'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DM_BUS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_txn_cnt   <= 32'b0;
      perf_stall_cnt <= 32'b0;
    end else begin
      if (start) perf_txn_cnt   <= perf_txn_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dm_bus_sequencer.md
Name: dm_bus_sequencer

Overview:
- Multi-cycle sequencer between the MEM-stage data-memory request (byte-lane read/write enables, address, store data) and an external req/ack data bus with wait states.
- Stalls the pipeline while a transfer is in flight, lane-replicates store data, and extracts and extends load data from the returned word.
- Bounds every bus transfer with a timeout.

Parameters:
- TIMEOUT_CYCLES, 15: REQ-state cycles without bus_ack before the transfer is abandoned (1..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- mem_we  in  4  store byte enables from MEM stage (0001/0010/0100/1000/0011/1100/1111, 0000 = none)
- mem_re  in  4  load byte enables, same encoding
- load_signed  in  1  sign-extend load result (LB/LH)
- mem_addr  in  32  byte address from the ALU
- mem_wdata  in  32  unshifted rt value
- stall  out  1  hold IF/ID/EX/MEM pipeline registers
- rdata  out  32  aligned, extended load result
- rdata_valid  out  1  rdata valid this cycle
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_be  out  4  byte enables
- bus_addr  out  32  {mem_addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transfer complete
- bus_rdata  in  32  read word, valid with bus_ack
- bus_timeout  out  1  sticky timeout flag
- illegal_req  out  1  one-cycle pulse: mem_we and mem_re both nonzero

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE; bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, rdata_valid=0, bus_timeout=0, illegal_req=0, timeout counter=0. Combinational stall is 0 while reset_n=0.
- Reset mid-transfer: bus_req drops at the same edge. A bus_ack in that cycle is ignored.
- States:
  - IDLE: access = (mem_we!=0)|(mem_re!=0). If access, latch addr/be/we/load_signed/wdata and go to REQ.
  - REQ: bus_req=1 with latched fields.
    - bus_ack=1: capture bus_rdata, go to DONE.
    - Counter reaches TIMEOUT_CYCLES-1 without ack: set bus_timeout, rdata=0, go to DONE.
    - Otherwise increment the counter.
  - DONE: rdata_valid=1 for exactly one cycle (loads and timed-out loads only). Always returns to IDLE. Requests present during DONE are ignored; they belong to the instruction that retires at this edge.
- stall = (state==IDLE & access) | (state==REQ). stall is 0 in DONE.
- Minimum cost with ack in the first REQ cycle: 2 stall cycles.
- Write priority: if both enables are nonzero, perform the write only and pulse illegal_req during the IDLE cycle.
- Store data:
  - Byte: {4{mem_wdata[7:0]}}
  - Half: {2{mem_wdata[15:0]}}
  - Word: mem_wdata
- Load extraction (by latched be):
  - 0001 -> [7:0]; 0010 -> [15:8]; 0100 -> [23:16]; 1000 -> [31:24]
  - 0011 -> [15:0]; 1100 -> [31:16]; 1111 -> full word
  - Extension: sign-extend from bit 7/15 if load_signed, else zero-extend.
- bus_timeout clears only on reset. The counter clears on entering REQ.
- bus_req stays high, with all bus fields stable, until ack or timeout.

Optional Feature:
- Macro DM_BUS_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_txn_cnt[31:0] (increments on each IDLE->REQ transition) and perf_stall_cnt[31:0] (increments every cycle stall=1).
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: ports absent, no counter logic.

Test Plan:
- LW addr 0x0000_1004, mem_re=1111, ack after 3 REQ cycles with bus_rdata=0xDEADBEEF -> bus_addr=0x1004, bus_be=1111, stall high for 4 cycles, DONE rdata=0xDEADBEEF, rdata_valid pulses once.
- LB addr 0x2003, mem_re=1000, load_signed=1, bus_rdata=0x80123456, immediate ack -> rdata=0xFFFFFF80. Repeat with load_signed=0 -> 0x00000080.
- SH addr 0x3002, mem_we=1100, mem_wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, rdata_valid stays 0.
- No ack for TIMEOUT_CYCLES=15 on an LW -> bus_req high exactly 15 cycles then low, bus_timeout=1 and remains 1, rdata=0 with rdata_valid pulse, stall releases.
- mem_we=1111 and mem_re=1111 together -> illegal_req pulse, bus_we=1, bus_be=1111.
- reset_n=0 during REQ cycle 2 -> next cycle bus_req=0, stall=0, state IDLE, bus_timeout=0. A fresh LW then completes normally.
